// File: rtl/soc_addr_route.sv
// Address router: decodes each request against the SoC region map into a slave index,
// buffers it in a two-entry spill pipeline and keeps a saturating unmapped-request log.
module soc_addr_route #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdWidth   = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [AddrWidth-1:0] in_addr_i,
    input  logic [IdWidth-1:0]   in_id_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [AddrWidth-1:0] out_addr_o,
    output logic [IdWidth-1:0]   out_id_o,
    output logic [3:0]           out_idx_o,
    output logic                 out_decerr_o,
    input  logic                 err_clear_i,
    output logic [15:0]          err_count_o,
    output logic [AddrWidth-1:0] err_addr_o,
    output logic                 err_valid_o
);

    localparam int unsigned NumRegions = 14;
    localparam int unsigned CmpWidth   = (AddrWidth > 64) ? AddrWidth : 64;

    typedef logic [63:0] word_t;

    localparam word_t RegionBase [NumRegions] = '{
        64'h0000_0000, 64'h0001_0000, 64'h0200_0000, 64'h0C00_0000,
        64'h1000_0000, 64'h1040_0000, 64'h1A10_0000, 64'h1800_0000,
        64'h1C00_0000, 64'h2000_0000, 64'h3000_0000, 64'h4000_0000,
        64'h7000_0000, 64'h8000_0000
    };
    localparam word_t RegionLen [NumRegions] = '{
        64'h0000_1000, 64'h0001_0000, 64'h000C_0000, 64'h03FF_FFFF,
        64'h0040_0000, 64'h0010_0000, 64'h0012_3000, 64'h0000_1000,
        64'h0001_0000, 64'h0080_0000, 64'h0001_0000, 64'h0000_1000,
        64'h0004_0000, 64'h2000_0000
    };
    localparam logic [3:0] RegionIdx [NumRegions] = '{
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd11, 4'd6,
        4'd7, 4'd5, 4'd8, 4'd9, 4'd10, 4'd12, 4'd12
    };

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [IdWidth-1:0]   id;
        logic [3:0]           idx;
        logic                 decerr;
    } entry_t;

    // ---------------- decode ----------------
    logic [CmpWidth-1:0]   addr_ext;
    logic [NumRegions-1:0] region_hit;
    logic [3:0]            dec_idx;
    logic                  dec_err;

    assign addr_ext = CmpWidth'(in_addr_i);

    generate
        for (genvar gi = 0; gi < NumRegions; gi++) begin : g_region
            localparam logic [CmpWidth-1:0] Lo = CmpWidth'(RegionBase[gi]);
            localparam logic [CmpWidth-1:0] Hi = CmpWidth'(RegionBase[gi]) + CmpWidth'(RegionLen[gi]);
            assign region_hit[gi] = (addr_ext >= Lo) && (addr_ext < Hi);
        end
    endgenerate

    // Regions never overlap, so OR-ing the hit indices selects the single match.
    always_comb begin
        dec_idx = 4'd0;
        for (int i = 0; i < NumRegions; i++) begin
            if (region_hit[i]) begin
                dec_idx = dec_idx | RegionIdx[i];
            end
        end
    end

    assign dec_err = ~|region_hit;

    // ---------------- two-entry pipeline ----------------
    entry_t     entry_mem [2];
    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic [1:0] count_next;
    logic       in_ready_reg;
    logic       push;
    logic       pop;
    entry_t     head;

    assign push = in_valid_i && in_ready_reg;
    assign pop  = out_valid_o && out_ready_i;

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 2'd1;
        end else if (!push && pop) begin
            count_next = count_reg - 2'd1;
        end
    end

    // Ready is a flop of "not full after this edge", so a full pipe drained this
    // cycle only reopens the input on the following cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            count_reg    <= 2'd0;
            in_ready_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            in_ready_reg <= (count_next != 2'd2);
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            entry_mem[wr_ptr_reg] <= '{addr: in_addr_i, id: in_id_i, idx: dec_idx, decerr: dec_err};
        end
    end

    assign head         = entry_mem[rd_ptr_reg];
    assign in_ready_o   = in_ready_reg;
    assign out_valid_o  = (count_reg != 2'd0);
    assign out_addr_o   = head.addr;
    assign out_id_o     = head.id;
    assign out_idx_o    = head.idx;
    assign out_decerr_o = head.decerr;

    // ---------------- unmapped-request log ----------------
    logic                 err_hit;
    logic [15:0]          err_count_reg;
    logic [AddrWidth-1:0] err_addr_reg;
    logic                 err_valid_reg;

    assign err_hit = push && dec_err;

    // A new error in the same cycle as a clear wins over the clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_count_reg <= 16'd0;
            err_addr_reg  <= '0;
            err_valid_reg <= 1'b0;
        end else if (err_hit) begin
            if (err_clear_i) begin
                err_count_reg <= 16'd1;
            end else if (err_count_reg != 16'hFFFF) begin
                err_count_reg <= err_count_reg + 16'd1;
            end
            if (err_clear_i || !err_valid_reg) begin
                err_addr_reg  <= in_addr_i;
                err_valid_reg <= 1'b1;
            end
        end else if (err_clear_i) begin
            err_count_reg <= 16'd0;
            err_addr_reg  <= '0;
            err_valid_reg <= 1'b0;
        end
    end

    assign err_count_o = err_count_reg;
    assign err_addr_o  = err_addr_reg;
    assign err_valid_o = err_valid_reg;

endmodule

// File: tb/tb_soc_addr_route.sv
// Scoreboard bench for soc_addr_route: expectations queued at input handshake,
// compared when the routed request leaves; also checks hold, backpressure, error log and reset.
module tb_soc_addr_route;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [63:0] in_addr_i;
    logic [4:0]  in_id_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] out_addr_o;
    logic [4:0]  out_id_o;
    logic [3:0]  out_idx_o;
    logic        out_decerr_o;
    logic        err_clear_i;
    logic [15:0] err_count_o;
    logic [63:0] err_addr_o;
    logic        err_valid_o;

    always #5 clk_i = ~clk_i;

    soc_addr_route #(.AddrWidth(64), .IdWidth(5)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_addr_i    (in_addr_i),
        .in_id_i      (in_id_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_addr_o   (out_addr_o),
        .out_id_o     (out_id_o),
        .out_idx_o    (out_idx_o),
        .out_decerr_o (out_decerr_o),
        .err_clear_i  (err_clear_i),
        .err_count_o  (err_count_o),
        .err_addr_o   (err_addr_o),
        .err_valid_o  (err_valid_o)
    );

    typedef struct packed {
        logic [63:0] addr;
        logic [4:0]  id;
        logic [3:0]  idx;
        logic        decerr;
    } exp_t;

    localparam logic [63:0] TbBase [14] = '{
        64'h0, 64'h1_0000, 64'h200_0000, 64'hC00_0000, 64'h1000_0000, 64'h1040_0000,
        64'h1A10_0000, 64'h1800_0000, 64'h1C00_0000, 64'h2000_0000, 64'h3000_0000,
        64'h4000_0000, 64'h7000_0000, 64'h8000_0000
    };
    localparam logic [63:0] TbLen [14] = '{
        64'h1000, 64'h1_0000, 64'hC_0000, 64'h3FF_FFFF, 64'h40_0000, 64'h10_0000,
        64'h12_3000, 64'h1000, 64'h1_0000, 64'h80_0000, 64'h1_0000, 64'h1000,
        64'h4_0000, 64'h2000_0000
    };
    localparam logic [3:0] TbIdx [14] = '{
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd11, 4'd6, 4'd7, 4'd5, 4'd8, 4'd9, 4'd10, 4'd12, 4'd12
    };

    exp_t sb_q[$];
    exp_t mon_e;
    exp_t held;
    bit   stall_prev = 1'b0;
    bit   quiet = 1'b0;
    bit   rand_done = 1'b0;
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic void ref_decode(input logic [63:0] a, output logic [3:0] idx, output logic de);
        idx = 4'd0;
        de  = 1'b1;
        for (int r = 0; r < 14; r++) begin
            if (a >= TbBase[r] && a - TbBase[r] < TbLen[r]) begin
                idx = TbIdx[r];
                de  = 1'b0;
            end
        end
    endfunction

    // Offer one request; expectation is queued in the cycle its handshake completes.
    task automatic send(input logic [63:0] a, input logic [4:0] id, input logic [3:0] xi, input logic xe);
        int n = 0;
        in_valid_i = 1'b1;
        in_addr_i  = a;
        in_id_i    = id;
        @(negedge clk_i);
        while (!in_ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (!in_ready_o) begin
            check("send_timeout", 80'(in_ready_o), 80'd1);
            in_valid_i = 1'b0;
        end else begin
            sb_q.push_back('{addr: a, id: id, idx: xi, decerr: xe});
            @(posedge clk_i);
            #1;
            in_valid_i = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb_q.size() != 0 || out_valid_o) && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check("drain_timeout", 80'(n < 200), 80'd1);
        @(posedge clk_i);
        #1;
    endtask

    // Output monitor: pops the scoreboard on every downstream handshake, checks stall hold.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 80'(out_valid_o), 80'd1);
                check("hold_data", 80'({out_addr_o, out_id_o, out_idx_o, out_decerr_o}), 80'(held));
            end
            if (out_valid_o && out_ready_i) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out", 80'(out_addr_o), 80'hFFFF_FFFF_FFFF_FFFF_FFFF);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("out_addr", 80'(out_addr_o), 80'(mon_e.addr));
                    check("out_id", 80'(out_id_o), 80'(mon_e.id));
                    check("out_idx", 80'(out_idx_o), 80'(mon_e.idx));
                    check("out_decerr", 80'(out_decerr_o), 80'(mon_e.decerr));
                    if (!quiet) begin
                        $display("TXN addr=0x%0h id=%0d idx=%0d decerr=%0d",
                                 out_addr_o, out_id_o, out_idx_o, out_decerr_o);
                    end
                end
            end
            stall_prev = out_valid_o && !out_ready_i;
            held = '{addr: out_addr_o, id: out_id_o, idx: out_idx_o, decerr: out_decerr_o};
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] a;
        logic [3:0]  xi;
        logic        xe;
        int          r;

        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        in_addr_i   = '0;
        in_id_i     = '0;
        out_ready_i = 1'b1;
        err_clear_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_out_valid", 80'(out_valid_o), 80'd0);
        check("rst_in_ready", 80'(in_ready_o), 80'd0);
        check("rst_err_count", 80'(err_count_o), 80'd0);
        check("rst_err_valid", 80'(err_valid_o), 80'd0);
        check("rst_err_addr", 80'(err_addr_o), 80'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("ready_after_rst", 80'(in_ready_o), 80'd1);

        // Single request, one-cycle latency
        send(64'h4000_0800, 5'd3, 4'd10, 1'b0);
        check("lat_valid", 80'(out_valid_o), 80'd1);
        check("lat_idx", 80'(out_idx_o), 80'd10);
        check("lat_decerr", 80'(out_decerr_o), 80'd0);
        check("lat_id", 80'(out_id_o), 80'd3);
        wait_drain();

        // Region boundaries, back to back
        send(64'h1040_0000, 5'd1, 4'd11, 1'b0);
        send(64'h103F_FFFF, 5'd2, 4'd4, 1'b0);
        send(64'h7003_FFFF, 5'd4, 4'd12, 1'b0);
        send(64'h1_0000_0000, 5'd5, 4'd0, 1'b1);
        wait_drain();

        // Backpressure: two accepted, third held off until the pipe drains
        out_ready_i = 1'b0;
        send(64'h1800_0010, 5'd6, 4'd7, 1'b0);
        send(64'h2000_0020, 5'd7, 4'd8, 1'b0);
        in_valid_i = 1'b1;
        in_addr_i  = 64'h3000_0030;
        in_id_i    = 5'd8;
        repeat (3) @(negedge clk_i);
        check("full_in_ready", 80'(in_ready_o), 80'd0);
        check("full_head_addr", 80'(out_addr_o), 80'h1800_0010);
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b1;
        @(negedge clk_i);
        check("full_pop_no_accept", 80'(in_ready_o), 80'd0);
        send(64'h3000_0030, 5'd8, 4'd9, 1'b0);
        wait_drain();

        // Error log: first address captured, count accumulates
        err_clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        err_clear_i = 1'b0;
        check("clr_count", 80'(err_count_o), 80'd0);
        check("clr_valid", 80'(err_valid_o), 80'd0);
        send(64'h5000_0000, 5'd9, 4'd0, 1'b1);
        send(64'h6000_0000, 5'd10, 4'd0, 1'b1);
        check("err_count2", 80'(err_count_o), 80'd2);
        check("err_addr_first", 80'(err_addr_o), 80'h5000_0000);
        check("err_valid", 80'(err_valid_o), 80'd1);
        err_clear_i = 1'b1;
        send(64'h6000_0000, 5'd11, 4'd0, 1'b1);
        err_clear_i = 1'b0;
        check("clr_new_count", 80'(err_count_o), 80'd1);
        check("clr_new_addr", 80'(err_addr_o), 80'h6000_0000);
        check("clr_new_valid", 80'(err_valid_o), 80'd1);
        wait_drain();

        // Randomised boundary stimulus under random backpressure
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    r = $urandom_range(0, 13);
                    case ($urandom_range(0, 4))
                        0:       a = TbBase[r];
                        1:       a = TbBase[r] + TbLen[r] - 64'd1;
                        2:       a = TbBase[r] + TbLen[r];
                        3:       a = TbBase[r] - 64'd1;
                        default: a = {$urandom, $urandom};
                    endcase
                    ref_decode(a, xi, xe);
                    send(a, 5'($urandom), xi, xe);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk_i);
                    #1;
                    out_ready_i = ($urandom_range(0, 3) != 0);
                end
                out_ready_i = 1'b1;
            end
        join
        wait_drain();

        // Saturation of the error counter
        err_clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        err_clear_i = 1'b0;
        quiet = 1'b1;
        for (int k = 0; k < 65540; k++) begin
            send(64'hDEAD_0000_0000 + 64'(k), 5'(k), 4'd0, 1'b1);
        end
        wait_drain();
        quiet = 1'b0;
        check("sat_count", 80'(err_count_o), 80'hFFFF);
        check("sat_addr", 80'(err_addr_o), 80'hDEAD_0000_0000);

        // Reset with both entries full: nothing stale may emerge
        out_ready_i = 1'b0;
        send(64'h1C00_0004, 5'd12, 4'd5, 1'b0);
        send(64'h0000_0800, 5'd13, 4'd0, 1'b0);
        rst_ni = 1'b0;
        #1;
        check("midrst_out_valid", 80'(out_valid_o), 80'd0);
        check("midrst_in_ready", 80'(in_ready_o), 80'd0);
        check("midrst_err_count", 80'(err_count_o), 80'd0);
        sb_q.delete();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        check("post_rst_idle", 80'(out_valid_o), 80'd0);
        send(64'h1C00_0010, 5'd14, 4'd5, 1'b0);
        wait_drain();
        check("sb_empty", 80'(sb_q.size()), 80'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/soc_addr_route.md
SOC_ADDR_ROUTE -- requirements
Module: soc_addr_route

Interface
REQ-001 SHALL have parameter AddrWidth, default 64, request address width.
REQ-002 SHALL have parameter IdWidth, default 5, transaction ID width.
REQ-003 SHALL have port clk_i, input, 1, the only clock; all flops rise on its positive edge.
REQ-004 SHALL have port rst_ni, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid_i, input, 1, upstream request valid.
REQ-006 SHALL have port in_ready_o, output, 1, upstream request ready.
REQ-007 SHALL have port in_addr_i, input, AddrWidth, request address.
REQ-008 SHALL have port in_id_i, input, IdWidth, request ID.
REQ-009 SHALL have port out_valid_o, output, 1, routed request valid.
REQ-010 SHALL have port out_ready_i, input, 1, crossbar ready.
REQ-011 SHALL have port out_addr_o, output, AddrWidth, address passed through unchanged.
REQ-012 SHALL have port out_id_o, output, IdWidth, ID passed through unchanged.
REQ-013 SHALL have port out_idx_o, output, 4, target slave index.
REQ-014 SHALL have port out_decerr_o, output, 1, request is unmapped.
REQ-015 SHALL have port err_clear_i, input, 1, clears the error counter and the capture register.
REQ-016 SHALL have port err_count_o, output, 16, count of unmapped requests, saturating.
REQ-017 SHALL have port err_addr_o, output, AddrWidth, address of the first unmapped request since the last clear.
REQ-018 SHALL have port err_valid_o, output, 1, err_addr_o holds a captured address.

Function
REQ-019 SHALL treat a region as a hit when base <= addr < base+length, using a full 64-bit unsigned compare.
REQ-020 SHALL use this region map (region: index, base, length):
- Debug: 0, 0x0, 0x1000
- ROM: 1, 0x1_0000, 0x1_0000
- CLINT: 2, 0x200_0000, 0xC_0000
- PLIC: 3, 0xC00_0000, 0x3FF_FFFF
- Cluster: 4, 0x1000_0000, 0x40_0000
- AXILite: 11, 0x1040_0000, 0x10_0000
- APB_SLVS: 6, 0x1A10_0000, 0x12_3000
- Timer: 7, 0x1800_0000, 0x1000
- L2SPM: 5, 0x1C00_0000, 0x1_0000
- SPI: 8, 0x2000_0000, 0x80_0000
- Ethernet: 9, 0x3000_0000, 0x1_0000
- UART: 10, 0x4000_0000, 0x1000
- LLCSPM: 12, 0x7000_0000, 0x4_0000
- HYAXI: 12, 0x8000_0000, 0x2000_0000
REQ-021 SHALL set out_decerr_o=1 and out_idx_o=0 for any address that hits no region, including any address with a nonzero bit in [63:32].
REQ-022 SHALL implement decode as a spill-register pipeline: two entries, 1-cycle latency from input handshake to out_valid_o, and one request per cycle sustained when out_ready_i=1.
REQ-023 SHALL drive in_ready_o directly from a flop: high when at least one entry is free, low when both entries are full.
REQ-024 SHALL hold out_addr_o, out_id_o, out_idx_o and out_decerr_o stable while out_valid_o=1 and out_ready_i=0.
REQ-025 SHALL deliver requests in acceptance order; no request is dropped or duplicated.
REQ-026 SHALL, in the same cycle as both a full pipeline (both entries full) and out_ready_i=1, accept no new input; input acceptance resumes the following cycle.
REQ-027 SHALL increment err_count_o on each input handshake whose address decodes as unmapped, saturating at 0xFFFF.
REQ-028 SHALL, on an unmapped handshake while err_valid_o=0, capture in_addr_i into err_addr_o and set err_valid_o; later errors do not overwrite the capture.
REQ-029 SHALL, when err_clear_i=1, set err_count_o=0 and err_valid_o=0 on the next edge.
REQ-030 SHALL, when err_clear_i=1 coincides with an unmapped handshake, make the new error win: err_count_o=1, err_valid_o=1, err_addr_o = the new address.
REQ-031 SHALL not let err_clear_i affect the request pipeline.

Reset
REQ-032 SHALL, while rst_ni=0, force:
- out_valid_o=0, in_ready_o=0
- both pipeline entries empty
- err_count_o=0, err_valid_o=0, err_addr_o=0
REQ-033 SHALL drive in_ready_o=1 on the first clock edge after rst_ni deasserts.
REQ-034 SHALL, on reset asserted mid-transfer, discard in-flight requests without ever presenting them downstream.

Verification
REQ-035 Bench: addr 0x4000_0800, id 3, out_ready_i=1 -> next cycle out_valid_o=1, idx=10, decerr=0, id=3.
REQ-036 Bench: addrs 0x1040_0000, 0x103F_FFFF, 0x7003_FFFF, 0x1_0000_0000 -> idx 11, 4, 12, then decerr=1 with idx 0.
REQ-037 Bench: out_ready_i=0 with 3 requests offered -> 2 accepted, in_ready_o=0; release -> both delivered in order, then the third is accepted.
REQ-038 Bench: unmapped 0x5000_0000 then 0x6000_0000 -> err_count_o=2, err_addr_o=0x5000_0000, err_valid_o=1.
REQ-039 Bench: err_clear_i together with unmapped 0x6000_0000 -> err_count_o=1, err_addr_o=0x6000_0000.
REQ-040 Bench: 65540 unmapped requests -> err_count_o=0xFFFF; rst_ni pulsed with 2 entries full -> out_valid_o=0 and no stale output afterwards.
